// File: rtl/mux_rr_nx1_pkg.sv
// Shared types and width helpers for the round-robin N:1 channel multiplexer.
package mux_rr_nx1_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Widths are derived from the instance parameters, so they are exposed as
    // functions; a single-value count still needs one bit of storage.
    function automatic int unsigned grant_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int unsigned burst_w(input int unsigned burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_nx1_rr_arbiter.sv
// One-hot arbiter: round-robin search from ptr+1, or fixed lowest-index priority.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned GW     = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [GW-1:0]     ptr_i,
    input  logic              rr_mode_i,
    output logic [NUM_CH-1:0] gnt_o
);

    logic        found;
    int unsigned idx;
    int unsigned start;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        start = 32'(ptr_i) + 1;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = rr_mode_i ? ((start + k) % NUM_CH) : k;
            if (!found && req_i[idx[GW-1:0]]) begin
                gnt_o[idx[GW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_nx1.sv
// N:1 multiplexer draining show-ahead FIFOs with round-robin/fixed arbitration and burst hold.
module mux_rr_nx1
    import mux_rr_nx1_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 12,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned BURST_LEN = 1,
    parameter int unsigned RR_MODE   = 1
) (
    input  logic                          clk,
    input  logic                          reset_L,
    input  logic [NUM_CH*DATA_SIZE-1:0]   data_in,
    input  logic [NUM_CH-1:0]             valid_in,
    input  logic                          ready_in,
    output logic [NUM_CH-1:0]             pop,
    output logic [DATA_SIZE-1:0]          data_out,
    output logic                          valid_out,
    output logic [$clog2(NUM_CH)-1:0]     grant_id
);

    localparam int unsigned     GW       = grant_w(NUM_CH);
    localparam int unsigned     CW       = burst_w(BURST_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(BURST_LEN - 1);

    state_e                 state_q, state_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [CW-1:0]          burst_cnt_q, burst_cnt_d;
    logic [DATA_SIZE-1:0]   data_out_q, data_out_d;
    logic                   valid_out_q, valid_out_d;
    logic [GW-1:0]          grant_id_q, grant_id_d;

    logic [NUM_CH-1:0]      arb_gnt;
    logic [NUM_CH-1:0]      hold_vec;
    logic [NUM_CH-1:0]      sel_vec;
    logic                   hold_active;
    logic                   xfer;
    logic                   popped;
    logic [GW-1:0]          pop_idx;
    logic [DATA_SIZE-1:0]   pop_word;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .GW     (GW)
    ) u_arb (
        .req_i     (valid_in),
        .ptr_i     (last_grant_q),
        .rr_mode_i (RR_MODE != 0),
        .gnt_o     (arb_gnt)
    );

    // While a burst is live the held channel bypasses the arbiter entirely.
    always_comb begin
        hold_vec               = '0;
        hold_vec[last_grant_q] = 1'b1;
        hold_active            = (state_q == HOLD) && valid_in[last_grant_q];
        xfer                   = reset_L && ready_in && (|valid_in);
        sel_vec                = hold_active ? hold_vec : arb_gnt;
        pop                    = xfer ? sel_vec : '0;
        popped                 = |pop;
        pop_idx                = '0;
        pop_word               = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (pop[k]) begin
                pop_idx  = GW'(k);
                pop_word = data_in[k*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        data_out_d   = data_out_q;
        valid_out_d  = popped;
        grant_id_d   = grant_id_q;
        if (popped) begin
            data_out_d   = pop_word;
            grant_id_d   = pop_idx;
            last_grant_d = pop_idx;
            if (hold_active) begin
                if (burst_cnt_q + CW'(1) == CNT_LAST) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
            end else begin
                burst_cnt_d = '0;
                state_d     = (BURST_LEN > 1) ? HOLD : IDLE;
            end
        end else if ((state_q == HOLD) && !valid_in[last_grant_q]) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_CH - 1);
            burst_cnt_q  <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            grant_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed bench: three instances (RR burst 1, RR burst 4, fixed priority) on a shared clock and reset.
module tb_mux_rr_nx1;

    logic        clk = 1'b0;
    logic        reset_L;
    logic [47:0] din;
    logic [3:0]  vin   [3];
    logic        rdy   [3];
    logic [3:0]  pop_w [3];
    logic [11:0] dout  [3];
    logic        vout  [3];
    logic [1:0]  gid   [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_rr_nx1 #(.DATA_SIZE(12), .NUM_CH(4), .BURST_LEN(1), .RR_MODE(1)) u_rr1 (
        .clk(clk), .reset_L(reset_L), .data_in(din), .valid_in(vin[0]), .ready_in(rdy[0]),
        .pop(pop_w[0]), .data_out(dout[0]), .valid_out(vout[0]), .grant_id(gid[0]));

    mux_rr_nx1 #(.DATA_SIZE(12), .NUM_CH(4), .BURST_LEN(4), .RR_MODE(1)) u_rr4 (
        .clk(clk), .reset_L(reset_L), .data_in(din), .valid_in(vin[1]), .ready_in(rdy[1]),
        .pop(pop_w[1]), .data_out(dout[1]), .valid_out(vout[1]), .grant_id(gid[1]));

    mux_rr_nx1 #(.DATA_SIZE(12), .NUM_CH(4), .BURST_LEN(1), .RR_MODE(0)) u_fix (
        .clk(clk), .reset_L(reset_L), .data_in(din), .valid_in(vin[2]), .ready_in(rdy[2]),
        .pop(pop_w[2]), .data_out(dout[2]), .valid_out(vout[2]), .grant_id(gid[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check pop combinationally, then the registered outputs.
    task automatic step(input int d, input logic [3:0] v, input logic r,
                        input logic [3:0] e_pop, input logic [1:0] e_gid,
                        input logic [11:0] e_dat, input logic e_vld, input string tag);
        vin[d] = v;
        rdy[d] = r;
        #1;
        chk({tag, ".pop"}, 32'(pop_w[d]), 32'(e_pop));
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(vout[d]), 32'(e_vld));
        chk({tag, ".gid"},   32'(gid[d]),  32'(e_gid));
        chk({tag, ".data"},  32'(dout[d]), 32'(e_dat));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        din     = {12'h3A3, 12'h2A2, 12'h1A1, 12'h0A0};
        reset_L = 1'b1;
        for (int d = 0; d < 3; d++) begin
            vin[d] = 4'hF;
            rdy[d] = 1'b1;
        end

        #3 reset_L = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst.pop",   32'(pop_w[d]), 32'h0);
            chk("rst.valid", 32'(vout[d]),  32'h0);
            chk("rst.data",  32'(dout[d]),  32'h0);
            chk("rst.gid",   32'(gid[d]),   32'h0);
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) vin[d] = 4'h0;
        reset_L = 1'b1;

        // Round-robin, burst 1, all channels valid
        step(0, 4'hF, 1'b1, 4'b0001, 2'd0, 12'h0A0, 1'b1, "rr_all0");
        step(0, 4'hF, 1'b1, 4'b0010, 2'd1, 12'h1A1, 1'b1, "rr_all1");
        step(0, 4'hF, 1'b1, 4'b0100, 2'd2, 12'h2A2, 1'b1, "rr_all2");
        step(0, 4'hF, 1'b1, 4'b1000, 2'd3, 12'h3A3, 1'b1, "rr_all3");
        step(0, 4'hF, 1'b1, 4'b0001, 2'd0, 12'h0A0, 1'b1, "rr_all4");
        // Sparse requests, wrap from channel 3 back to 1
        step(0, 4'hA, 1'b1, 4'b0010, 2'd1, 12'h1A1, 1'b1, "sparse0");
        step(0, 4'hA, 1'b1, 4'b1000, 2'd3, 12'h3A3, 1'b1, "sparse1");
        step(0, 4'hA, 1'b1, 4'b0010, 2'd1, 12'h1A1, 1'b1, "sparse_wrap");
        step(0, 4'hA, 1'b1, 4'b1000, 2'd3, 12'h3A3, 1'b1, "sparse3");
        // Backpressure
        step(0, 4'hF, 1'b1, 4'b0001, 2'd0, 12'h0A0, 1'b1, "bp_pre");
        step(0, 4'hF, 1'b0, 4'b0000, 2'd0, 12'h0A0, 1'b0, "bp_stall0");
        step(0, 4'hF, 1'b0, 4'b0000, 2'd0, 12'h0A0, 1'b0, "bp_stall1");
        step(0, 4'hF, 1'b0, 4'b0000, 2'd0, 12'h0A0, 1'b0, "bp_stall2");
        step(0, 4'hF, 1'b1, 4'b0010, 2'd1, 12'h1A1, 1'b1, "bp_resume0");
        step(0, 4'hF, 1'b1, 4'b0100, 2'd2, 12'h2A2, 1'b1, "bp_resume1");
        step(0, 4'h0, 1'b1, 4'b0000, 2'd2, 12'h2A2, 1'b0, "no_valid");
        vin[0] = 4'h0;

        // Round-robin, burst 4
        for (int k = 0; k < 4; k++) step(1, 4'hF, 1'b1, 4'b0001, 2'd0, 12'h0A0, 1'b1, "burst_ch0");
        for (int k = 0; k < 4; k++) step(1, 4'hF, 1'b1, 4'b0010, 2'd1, 12'h1A1, 1'b1, "burst_ch1");
        for (int k = 0; k < 4; k++) step(1, 4'hF, 1'b1, 4'b0100, 2'd2, 12'h2A2, 1'b1, "burst_ch2");
        for (int k = 0; k < 4; k++) step(1, 4'hF, 1'b1, 4'b1000, 2'd3, 12'h3A3, 1'b1, "burst_ch3");
        step(1, 4'hF, 1'b1, 4'b0001, 2'd0, 12'h0A0, 1'b1, "drop_pre0");
        step(1, 4'hF, 1'b1, 4'b0001, 2'd0, 12'h0A0, 1'b1, "drop_pre1");
        step(1, 4'hE, 1'b1, 4'b0010, 2'd1, 12'h1A1, 1'b1, "drop_switch");
        step(1, 4'hF, 1'b0, 4'b0000, 2'd1, 12'h1A1, 1'b0, "burst_stall0");
        step(1, 4'hF, 1'b0, 4'b0000, 2'd1, 12'h1A1, 1'b0, "burst_stall1");
        step(1, 4'hF, 1'b1, 4'b0010, 2'd1, 12'h1A1, 1'b1, "burst_resume0");
        step(1, 4'hF, 1'b1, 4'b0010, 2'd1, 12'h1A1, 1'b1, "burst_resume1");
        step(1, 4'hF, 1'b1, 4'b0010, 2'd1, 12'h1A1, 1'b1, "burst_resume2");
        step(1, 4'hF, 1'b1, 4'b0100, 2'd2, 12'h2A2, 1'b1, "burst_next");

        // Reset in the middle of the channel-2 burst
        #2 reset_L = 1'b0;
        #1;
        chk("midrst.pop",   32'(pop_w[1]), 32'h0);
        chk("midrst.valid", 32'(vout[1]),  32'h0);
        chk("midrst.data",  32'(dout[1]),  32'h0);
        chk("midrst.gid",   32'(gid[1]),   32'h0);
        @(negedge clk);
        reset_L = 1'b1;
        step(1, 4'hF, 1'b1, 4'b0001, 2'd0, 12'h0A0, 1'b1, "post_rst");
        vin[1] = 4'h0;

        // Fixed priority
        for (int k = 0; k < 4; k++) step(2, 4'h6, 1'b1, 4'b0010, 2'd1, 12'h1A1, 1'b1, "fixed_ch1");
        step(2, 4'hF, 1'b1, 4'b0001, 2'd0, 12'h0A0, 1'b1, "fixed_all");
        step(2, 4'h0, 1'b1, 4'b0000, 2'd0, 12'h0A0, 1'b0, "fixed_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_nx1.md
MUX_RR_NX1 -- requirements
Module: mux_rr_nx1

Interface
REQ-001 Parameter DATA_SIZE, default 12, width of each channel word.
REQ-002 Parameter NUM_CH, default 4, number of input channels (legal 2..16).
REQ-003 Parameter BURST_LEN, default 1, max consecutive words granted to one channel before re-arbitration (legal 1..16).
REQ-004 Parameter RR_MODE, default 1; 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset_L  input  1  reset, asynchronous assert, active-low.
REQ-007 data_in  input  NUM_CH*DATA_SIZE  channel i word at bits [i*DATA_SIZE +: DATA_SIZE], show-ahead from upstream FIFO.
REQ-008 valid_in  input  NUM_CH  bit i high: channel i word available.
REQ-009 ready_in  input  1  downstream can accept a word this cycle (inverse of downstream almost-full).
REQ-010 pop  output  NUM_CH  one-hot read strobe to upstream FIFO i, combinational.
REQ-011 data_out  output  DATA_SIZE  selected word, registered.
REQ-012 valid_out  output  1  data_out holds a new word this cycle, registered.
REQ-013 grant_id  output  $clog2(NUM_CH)  channel index of word on data_out, registered.

Function
REQ-014 Transfer condition per cycle: ready_in=1 and |valid_in=1; otherwise pop=0.
REQ-015 pop SHALL be one-hot or zero, and pop[i]=1 only when valid_in[i]=1.
REQ-016 Latency 1: word popped in cycle t appears on data_out with valid_out=1 and grant_id=i in cycle t+1.
REQ-017 valid_out=0 in any cycle following a cycle with no pop; data_out and grant_id hold last value.
REQ-018 Round-robin: search starts at (last_grant+1) mod NUM_CH, first channel with valid_in set wins, wrap-around from NUM_CH-1 to 0.
REQ-019 Fixed priority: lowest index with valid_in set wins; burst rule REQ-020 still applies.
REQ-020 Burst hold: after granting channel i, keep channel i while valid_in[i]=1 and burst_cnt < BURST_LEN-1; burst_cnt increments per pop of i.
REQ-021 Burst release: burst_cnt reaches BURST_LEN-1, or valid_in[i] drops -> re-arbitrate next cycle, burst_cnt clears on a grant change.
REQ-022 ready_in=0 mid-burst: no pop, burst_cnt and last_grant frozen; burst resumes on channel i when ready_in returns.
REQ-023 FSM states: IDLE (no active grant), HOLD (burst in progress on last_grant).
REQ-024 IDLE->HOLD on a pop with BURST_LEN>1; HOLD->IDLE on burst release or valid_in[last_grant]=0; BURST_LEN=1 never enters HOLD.
REQ-025 last_grant updates only on a pop; only one channel valid: that channel served every eligible cycle.

Reset
REQ-026 reset_L low asynchronously clears data_out=0, valid_out=0, grant_id=0, burst_cnt=0, state=IDLE.
REQ-027 last_grant resets to NUM_CH-1 so channel 0 wins the first round-robin arbitration.
REQ-028 pop=0 while reset_L low; reset mid-burst abandons the burst, no word lost beyond the popped one already registered.

Structure
REQ-029 Shared package holds the FSM state encoding (IDLE, HOLD) and the $clog2-derived widths for grant and burst counter.
REQ-030 One sub-module rr_arbiter (request vector, pointer, mode in; one-hot grant out); data path and FSM in mux_rr_nx1.

Verification
REQ-031 Reset: reset_L low at t=3 with all valid_in=1 -> pop=0, valid_out=0, data_out=0 immediately.
REQ-032 RR, BURST_LEN=1, valid_in=4'b1111, ready_in=1, data 0x0A0/0x1A1/0x2A2/0x3A3 -> grant_id 0,1,2,3,0 on consecutive cycles.
REQ-033 Sparse: valid_in=4'b1010 -> alternating grants 1,3,1,3; channel 3 to channel 1 wrap checked.
REQ-034 Backpressure: ready_in=0 for 3 cycles mid-stream -> pop=0, valid_out=0 after 1 cycle, order resumes without skip or duplicate.
REQ-035 BURST_LEN=4, all valid -> grant_id 0,0,0,0,1,1,1,1; drop valid_in[0] after 2 words -> switches to 1 next cycle.
REQ-036 RR_MODE=0, valid_in=4'b0110 constant -> channel 1 served every cycle, pop[2] never asserted.
